mem_stage: RTL and testbench

- Memory stage sitting directly downstream of the execute-stage ALU in the 16-bit pipelined core.
- Consumes the ALU result (effective address or plain result), the store data and a memory-class code.
- Drives a multi-cycle data memory through a request/done handshake and presents one registered result per instruction to writeback.
- Stalls upstream (in_ready low) while a memory access is outstanding.

---
 rtl/core_pkg.sv | 29 ++
 rtl/mem_wait_ctr.sv | 32 +++
 rtl/mem_stage.sv | 178 +++++++++++++++++
 tb/tb_mem_stage.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit pipelined core.
// Contents:
//   DATA_W, REG_W : data path width and register-number width
//   mclass_t      : memory-class encoding carried down from execute
//   state_t       : memory-stage FSM state encoding
//   is_mem_op     : true for any class that touches data memory
package core_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;

    typedef enum logic [1:0] {
        MC_NONE = 2'd0,
        MC_LD   = 2'd1,
        MC_ST   = 2'd2,
        MC_STU  = 2'd3
    } mclass_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    function automatic logic is_mem_op(input mclass_t mc);
        return mc != MC_NONE;
    endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// Wait-cycle counter for the memory stage.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : count up by one this cycle
//   tc       : high while the count equals TIMEOUT-1
module mem_wait_ctr #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage.sv
// Memory stage: takes the ALU result, store data and memory class from
// execute, runs a request/done handshake with a multi-cycle data memory
// and hands one registered result per instruction to writeback.
// Ports:
//   clk, rst                        : clock, asynchronous active-high reset
//   in_valid/in_ready               : upstream handshake (ready only in IDLE)
//   in_mclass, in_alu_out, in_st_data, in_dest, in_wb_en : instruction fields
//   mem_addr, mem_wdata, mem_rd, mem_wr : memory request (level, held while stalled)
//   mem_stall, mem_done, mem_rdata  : memory back-pressure, completion, read data
//   out_valid, out_data, out_dest, out_wb_en, out_err : writeback result
module mem_stage
    import core_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_mclass,
    input  logic [DATA_W-1:0] in_alu_out,
    input  logic [DATA_W-1:0] in_st_data,
    input  logic [REG_W-1:0]  in_dest,
    input  logic              in_wb_en,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_stall,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [REG_W-1:0]  out_dest,
    output logic              out_wb_en,
    output logic              out_err
);

    state_t            state, next_state;
    mclass_t           in_mc;
    mclass_t           hold_mclass;
    logic [DATA_W-1:0] hold_alu;
    logic [REG_W-1:0]  hold_dest;
    logic              hold_wb_en;
    logic              accept_mem, accept_bad;
    logic              ctr_clr, ctr_en, ctr_tc;

    assign in_mc      = mclass_t'(in_mclass);
    assign in_ready   = (state == S_IDLE);
    // Aligned memory ops go to memory; a set bit 0 is rejected immediately.
    assign accept_mem = in_ready && in_valid && is_mem_op(in_mc) && !in_alu_out[0];
    assign accept_bad = in_ready && in_valid && is_mem_op(in_mc) &&  in_alu_out[0];

    mem_wait_ctr #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_ctr (
        .clk (clk),
        .rst (rst),
        .clr (ctr_clr),
        .en  (ctr_en),
        .tc  (ctr_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The counter is cleared on the edge the memory accepts the request,
    // so the WAIT phase lasts at most TIMEOUT cycles.
    always_comb begin
        next_state = state;
        ctr_clr    = 1'b0;
        ctr_en     = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept_mem) next_state = S_REQ;
            end
            S_REQ: begin
                if (!mem_stall) begin
                    next_state = S_WAIT;
                    ctr_clr    = 1'b1;
                end
            end
            S_WAIT: begin
                ctr_en = 1'b1;
                if (mem_done || ctr_tc) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Holding registers, memory request registers and the writeback result.
    // out_valid and out_err are single-cycle; the rest hold their last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_mclass <= MC_NONE;
            hold_alu    <= '0;
            hold_dest   <= '0;
            hold_wb_en  <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_dest    <= '0;
            out_wb_en   <= 1'b0;
            out_err     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        hold_mclass <= in_mc;
                        hold_alu    <= in_alu_out;
                        hold_dest   <= in_dest;
                        hold_wb_en  <= in_wb_en;
                        if (!is_mem_op(in_mc)) begin
                            out_valid <= 1'b1;
                            out_data  <= in_alu_out;
                            out_dest  <= in_dest;
                            out_wb_en <= in_wb_en;
                        end else if (accept_bad) begin
                            out_valid <= 1'b1;
                            out_err   <= 1'b1;
                            out_data  <= in_alu_out;
                            out_dest  <= in_dest;
                            out_wb_en <= 1'b0;
                        end else begin
                            mem_addr  <= in_alu_out;
                            mem_wdata <= in_st_data;
                            mem_rd    <= (in_mc == MC_LD);
                            mem_wr    <= (in_mc != MC_LD);
                        end
                    end
                end
                S_REQ: begin
                    if (!mem_stall) begin
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                    end
                end
                S_WAIT: begin
                    // Completion on the terminal cycle counts as success.
                    if (mem_done) begin
                        out_valid <= 1'b1;
                        out_dest  <= hold_dest;
                        case (hold_mclass)
                            MC_LD: begin
                                out_data  <= mem_rdata;
                                out_wb_en <= hold_wb_en;
                            end
                            MC_STU: begin
                                out_data  <= hold_alu;
                                out_wb_en <= hold_wb_en;
                            end
                            default: begin
                                out_data  <= hold_alu;
                                out_wb_en <= 1'b0;
                            end
                        endcase
                    end else if (ctr_tc) begin
                        out_valid <= 1'b1;
                        out_err   <= 1'b1;
                        out_dest  <= hold_dest;
                        out_wb_en <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random
// instructions, each compared cycle by cycle against a timeline model that
// derives request windows, result cycle and result fields from the
// instruction's class, alignment, stall count and memory done delay.
module tb_mem_stage;
    import core_pkg::*;

    localparam int TO = 16;
    localparam int NEVER = 99;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_mclass = 2'd0;
    logic [15:0] in_alu_out = 16'h0;
    logic [15:0] in_st_data = 16'h0;
    logic [2:0]  in_dest = 3'd0;
    logic        in_wb_en = 1'b0;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_rd, mem_wr;
    logic        mem_stall = 1'b0;
    logic        mem_done = 1'b0;
    logic [15:0] mem_rdata = 16'h0;
    logic        out_valid;
    logic [15:0] out_data;
    logic [2:0]  out_dest;
    logic        out_wb_en, out_err;

    int n_assert = 0;
    int n_fail   = 0;

    mem_stage #(.TIMEOUT(TO), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mclass(in_mclass), .in_alu_out(in_alu_out), .in_st_data(in_st_data),
        .in_dest(in_dest), .in_wb_en(in_wb_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_stall(mem_stall), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_data(out_data), .out_dest(out_dest),
        .out_wb_en(out_wb_en), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One instruction, entered and left at a falling edge with the stage idle.
    // d = WAIT cycle (0-based) on which the memory pulses done; NEVER = never.
    task automatic applyStimulus(input logic [1:0] cls, input logic [15:0] alu,
                                 input logic [15:0] st, input logic [2:0] dest,
                                 input logic wb, input int stall_n, input int d,
                                 input logic [15:0] rdata, input logic spurious);
        logic go_mem, timed_out, exp_err, exp_wb;
        int   out_k, done_k;
        go_mem    = (cls != 2'd0) && !alu[0];
        timed_out = go_mem && (d > TO - 1);
        exp_err   = (cls != 2'd0) && (alu[0] || timed_out);
        exp_wb    = exp_err ? 1'b0 : (cls == 2'd2) ? 1'b0 : wb;
        done_k    = stall_n + 1 + d;
        out_k     = go_mem ? stall_n + 1 + ((d > TO - 1) ? TO - 1 : d) + 1 : 0;

        checkOutput("ready_before", in_ready, 1'b1);
        in_valid = 1'b1; in_mclass = cls; in_alu_out = alu; in_st_data = st;
        in_dest = dest; in_wb_en = wb;
        @(posedge clk);
        for (int k = 0; k <= out_k; k++) begin
            @(negedge clk);
            in_valid   = 1'b0;
            in_mclass  = 2'($urandom);
            in_alu_out = 16'($urandom);
            in_st_data = 16'($urandom);
            in_dest    = 3'($urandom);
            in_wb_en   = 1'($urandom);
            mem_stall  = go_mem && (k < stall_n);
            mem_done   = (go_mem && k == done_k) || (spurious && go_mem && k < stall_n);
            mem_rdata  = (k == done_k) ? rdata : 16'($urandom);
            checkOutput("out_valid", out_valid, (k == out_k));
            checkOutput("in_ready", in_ready, (k >= out_k));
            checkOutput("mem_rd", mem_rd, go_mem && cls == 2'd1 && k <= stall_n);
            checkOutput("mem_wr", mem_wr, go_mem && cls != 2'd1 && k <= stall_n);
            if (go_mem && k <= stall_n) begin
                checkOutput("mem_addr", mem_addr, alu);
                if (cls != 2'd1) checkOutput("mem_wdata", mem_wdata, st);
            end
            if (k == out_k) begin
                checkOutput("out_err", out_err, exp_err);
                checkOutput("out_wb_en", out_wb_en, exp_wb);
                checkOutput("out_dest", out_dest, dest);
                if (!exp_err && cls != 2'd2)
                    checkOutput("out_data", out_data, (cls == 2'd1) ? rdata : alu);
            end
        end
        mem_stall = 1'b0;
        mem_done  = 1'b0;
    endtask

    initial begin
        // Reset values
        @(negedge clk);
        checkOutput("rst_ready", in_ready, 1'b1);
        checkOutput("rst_valid", out_valid, 1'b0);
        checkOutput("rst_rd", mem_rd, 1'b0);
        checkOutput("rst_wr", mem_wr, 1'b0);
        checkOutput("rst_data", out_data, 16'h0);
        checkOutput("rst_dest", out_dest, 3'd0);
        checkOutput("rst_addr", mem_addr, 16'h0);
        checkOutput("rst_err", out_err, 1'b0);
        checkOutput("rst_wb", out_wb_en, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back NONE instructions, one result per cycle
        in_valid = 1'b1; in_mclass = 2'd0; in_alu_out = 16'h1234; in_dest = 3'd5; in_wb_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("b2b_valid", out_valid, 1'b1);
            checkOutput("b2b_data", out_data, 16'h1234);
            checkOutput("b2b_dest", out_dest, 3'd5);
            checkOutput("b2b_wb", out_wb_en, 1'b1);
            checkOutput("b2b_rdwr", {mem_rd, mem_wr}, 2'b00);
        end
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b_end", out_valid, 1'b0);

        // Directed memory scenarios
        applyStimulus(2'd1, 16'h0040, 16'h0000, 3'd1, 1'b1, 2, 0, 16'hBEEF, 1'b1);
        applyStimulus(2'd3, 16'h0102, 16'h00AA, 3'd2, 1'b1, 0, 1, 16'h0000, 1'b0);
        applyStimulus(2'd2, 16'h0102, 16'h00AA, 3'd3, 1'b1, 0, 1, 16'h0000, 1'b0);
        applyStimulus(2'd1, 16'h0041, 16'h0000, 3'd4, 1'b1, 0, 0, 16'h0000, 1'b0);
        applyStimulus(2'd1, 16'h0080, 16'h0000, 3'd6, 1'b1, 0, NEVER, 16'h0000, 1'b0);
        applyStimulus(2'd1, 16'h0082, 16'h0000, 3'd7, 1'b1, 1, TO - 1, 16'h5A5A, 1'b0);

        // Randomized instructions
        for (int i = 0; i < 40; i++) begin
            logic [15:0] a;
            int dd;
            a    = 16'($urandom);
            a[0] = ($urandom_range(0, 3) == 0);
            dd   = $urandom_range(0, 18);
            if (dd == 18) dd = NEVER;
            applyStimulus(2'($urandom_range(0, 3)), a, 16'($urandom), 3'($urandom),
                          1'($urandom), $urandom_range(0, 3), dd, 16'($urandom),
                          1'($urandom));
        end

        // Reset while a store request is held by a stalling memory
        in_valid = 1'b1; in_mclass = 2'd2; in_alu_out = 16'h0200; in_st_data = 16'h1111;
        @(negedge clk);
        in_valid = 1'b0; mem_stall = 1'b1;
        checkOutput("req_wr_before", mem_wr, 1'b1);
        #2 rst = 1'b1;
        #1 checkOutput("req_rst_wr", mem_wr, 1'b0);
        checkOutput("req_rst_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0; mem_stall = 1'b0;
        @(negedge clk);

        // Reset in the middle of WAIT, then a late done pulse
        in_valid = 1'b1; in_mclass = 2'd1; in_alu_out = 16'h0300;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("wait_ready", in_ready, 1'b0);
        #2 rst = 1'b1;
        #1 checkOutput("wait_rst_valid", out_valid, 1'b0);
        checkOutput("wait_rst_rdwr", {mem_rd, mem_wr}, 2'b00);
        checkOutput("wait_rst_ready", in_ready, 1'b1);
        checkOutput("wait_rst_addr", mem_addr, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_done = 1'b1; mem_rdata = 16'hDEAD;
            @(negedge clk);
            checkOutput("late_done_valid", out_valid, 1'b0);
            checkOutput("late_done_ready", in_ready, 1'b1);
        end
        mem_done = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
